// File: rtl/fec_codec_pipe.sv
// fec_codec_pipe: SECDED Hamming(8,4) loopback pipeline.
// Input FIFO -> encode -> channel (error injection) -> decode/correct -> output FIFO.
// One word is in flight at a time; the FSM walks IDLE/ENC/CHAN/DEC/PUSH.
module fec_codec_pipe #(
   parameter int unsigned MSG_W = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 mode,
   input  logic                 in_req,
   output logic                 in_ack,
   input  logic [MSG_W-1:0]     data_in,
   output logic                 out_req,
   input  logic                 out_ack,
   output logic [MSG_W-1:0]     data_out,
   output logic                 err_corr,
   output logic                 err_uncorr,
   input  logic                 inj_en,
   input  logic [2*MSG_W-1:0]   inj_mask,
   input  logic                 clr_cnt,
   output logic [CNT_W-1:0]     cnt_corr,
   output logic [CNT_W-1:0]     cnt_uncorr,
   output logic                 busy
);

   localparam int unsigned NIB  = MSG_W / 4;
   localparam int unsigned CW_W = 2 * MSG_W;
   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned NW   = $clog2(NIB + 1);
   localparam int unsigned OW   = MSG_W + 2;

   typedef enum logic [2:0] {IDLE, ENC, CHAN, DEC, PUSH} state_t;

   state_t state_q, state_d;
   logic   start, in_pop, out_push, out_pop, in_push;

   logic [MSG_W-1:0] in_mem [DEPTH];
   logic [OW-1:0]    out_mem [DEPTH];
   logic [AW-1:0]    in_wp_q, in_wp_d, in_rp_q, in_rp_d;
   logic [AW-1:0]    out_wp_q, out_wp_d, out_rp_q, out_rp_d;
   logic [AW:0]      in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
   logic             in_empty, in_full, out_empty, out_full;

   logic [MSG_W-1:0] word_q, word_d;
   logic             mode_q, mode_d;
   logic [CW_W-1:0]  cw_q, cw_d, enc_cw;
   logic [MSG_W-1:0] res_data_q, res_data_d, dc_data;
   logic [NW-1:0]    res_ncorr_q, res_ncorr_d, res_nunc_q, res_nunc_d;
   logic [NW-1:0]    dc_ncorr, dc_nunc;
   logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d, cnt_unc_q, cnt_unc_d;
   logic [OW-1:0]    head;

   function automatic logic [7:0] enc_nib(input logic [3:0] d);
      logic [7:0] c;
      c    = '0;
      c[3] = d[0];
      c[5] = d[1];
      c[6] = d[2];
      c[7] = d[3];
      c[1] = d[0] ^ d[1] ^ d[3];
      c[2] = d[0] ^ d[2] ^ d[3];
      c[4] = d[1] ^ d[2] ^ d[3];
      c[0] = ^c[7:1];
      return c;
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [NW-1:0] b);
      logic [CNT_W+NW-1:0] s;
      s = (CNT_W+NW)'(a) + (CNT_W+NW)'(b);
      return (s[CNT_W+NW-1:CNT_W] != '0) ? '1 : s[CNT_W-1:0];
   endfunction

   // Handshake and buffer status flags
   always_comb begin
      in_empty  = (in_cnt_q == '0);
      in_full   = (in_cnt_q == (AW+1)'(DEPTH));
      out_empty = (out_cnt_q == '0);
      out_full  = (out_cnt_q == (AW+1)'(DEPTH));
      in_ack    = en & ~in_full & ~rst;
      in_push   = in_req & in_ack;
      out_req   = ~out_empty;
      out_pop   = out_req & out_ack;
      head      = out_mem[out_rp_q];
      data_out  = out_req ? head[MSG_W-1:0] : '0;
      err_corr  = out_req & head[MSG_W];
      err_uncorr = out_req & head[MSG_W+1];
      cnt_corr  = cnt_corr_q;
      cnt_uncorr = cnt_unc_q;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = ENC;
         ENC:     state_d = CHAN;
         CHAN:    state_d = DEC;
         DEC:     state_d = PUSH;
         PUSH:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy     = (state_q != IDLE);
      start    = (state_q == IDLE) & en & ~in_empty & ~out_full;
      in_pop   = start;
      out_push = (state_q == PUSH);
   end

   // Buffer pointer and occupancy next-state
   always_comb begin
      in_wp_d   = in_push  ? in_wp_q  + AW'(1) : in_wp_q;
      in_rp_d   = in_pop   ? in_rp_q  + AW'(1) : in_rp_q;
      out_wp_d  = out_push ? out_wp_q + AW'(1) : out_wp_q;
      out_rp_d  = out_pop  ? out_rp_q + AW'(1) : out_rp_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      unique case ({in_push, in_pop})
         2'b10:   in_cnt_d = in_cnt_q + (AW+1)'(1);
         2'b01:   in_cnt_d = in_cnt_q - (AW+1)'(1);
         default: ;
      endcase
      unique case ({out_push, out_pop})
         2'b10:   out_cnt_d = out_cnt_q + (AW+1)'(1);
         2'b01:   out_cnt_d = out_cnt_q - (AW+1)'(1);
         default: ;
      endcase
   end

   // Buffer storage writes (contents need no reset; reads are gated by occupancy)
   always_ff @(posedge clk) begin
      if (in_push)  in_mem[in_wp_q]   <= data_in;
      if (out_push) out_mem[out_wp_q] <= {res_nunc_q != '0, res_ncorr_q != '0, res_data_q};
   end

   // Full-word encoder
   always_comb begin
      enc_cw = '0;
      for (int unsigned k = 0; k < NIB; k++) enc_cw[8*k +: 8] = enc_nib(word_q[4*k +: 4]);
   end

   // Per-nibble syndrome decode and single-error correction
   always_comb begin
      logic [7:0] c;
      logic [2:0] s;
      dc_data  = '0;
      dc_ncorr = '0;
      dc_nunc  = '0;
      for (int unsigned k = 0; k < NIB; k++) begin
         c = cw_q[8*k +: 8];
         s = {c[4]^c[5]^c[6]^c[7], c[2]^c[3]^c[6]^c[7], c[1]^c[3]^c[5]^c[7]};
         if (^c) begin
            c[s]     = ~c[s];
            dc_ncorr = dc_ncorr + NW'(1);
         end else if (s != 3'd0) begin
            dc_nunc  = dc_nunc + NW'(1);
         end
         dc_data[4*k +: 4] = {c[7], c[6], c[5], c[3]};
      end
   end

   // Per-stage datapath loads; bypass carries the raw word in the low codeword bits
   always_comb begin
      word_d      = word_q;
      mode_d      = mode_q;
      cw_d        = cw_q;
      res_data_d  = res_data_q;
      res_ncorr_d = res_ncorr_q;
      res_nunc_d  = res_nunc_q;
      unique case (state_q)
         IDLE: if (start) begin
            word_d = in_mem[in_rp_q];
            mode_d = mode;
         end
         ENC:  cw_d = mode_q ? enc_cw : CW_W'(word_q);
         CHAN: if (mode_q && inj_en) cw_d = cw_q ^ inj_mask;
         DEC: begin
            if (mode_q) begin
               res_data_d  = dc_data;
               res_ncorr_d = dc_ncorr;
               res_nunc_d  = dc_nunc;
            end else begin
               res_data_d  = cw_q[MSG_W-1:0];
               res_ncorr_d = '0;
               res_nunc_d  = '0;
            end
         end
         default: ;
      endcase
   end

   // Saturating error counters; clear wins over a same-cycle increment
   always_comb begin
      cnt_corr_d = cnt_corr_q;
      cnt_unc_d  = cnt_unc_q;
      if (clr_cnt) begin
         cnt_corr_d = '0;
         cnt_unc_d  = '0;
      end else if (out_push) begin
         cnt_corr_d = sat_add(cnt_corr_q, res_ncorr_q);
         cnt_unc_d  = sat_add(cnt_unc_q, res_nunc_q);
      end
   end

   // Register update for pointers, datapath and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         in_wp_q     <= '0;
         in_rp_q     <= '0;
         out_wp_q    <= '0;
         out_rp_q    <= '0;
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         word_q      <= '0;
         mode_q      <= 1'b0;
         cw_q        <= '0;
         res_data_q  <= '0;
         res_ncorr_q <= '0;
         res_nunc_q  <= '0;
         cnt_corr_q  <= '0;
         cnt_unc_q   <= '0;
      end else begin
         in_wp_q     <= in_wp_d;
         in_rp_q     <= in_rp_d;
         out_wp_q    <= out_wp_d;
         out_rp_q    <= out_rp_d;
         in_cnt_q    <= in_cnt_d;
         out_cnt_q   <= out_cnt_d;
         word_q      <= word_d;
         mode_q      <= mode_d;
         cw_q        <= cw_d;
         res_data_q  <= res_data_d;
         res_ncorr_q <= res_ncorr_d;
         res_nunc_q  <= res_nunc_d;
         cnt_corr_q  <= cnt_corr_d;
         cnt_unc_q   <= cnt_unc_d;
      end
   end

endmodule

// File: tb/tb_fec_codec_pipe.sv
// Directed bench for fec_codec_pipe (MSG_W=8, DEPTH=4, CNT_W=2).
module tb_fec_codec_pipe;

   logic        clk = 1'b0;
   logic        rst, en, mode, in_req, out_ack, inj_en, clr_cnt;
   logic        in_ack, out_req, err_corr, err_uncorr, busy;
   logic [7:0]  data_in, data_out;
   logic [15:0] inj_mask;
   logic [1:0]  cnt_corr, cnt_uncorr;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   fec_codec_pipe #(.MSG_W(8), .DEPTH(4), .CNT_W(2)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode),
      .in_req(in_req), .in_ack(in_ack), .data_in(data_in),
      .out_req(out_req), .out_ack(out_ack), .data_out(data_out),
      .err_corr(err_corr), .err_uncorr(err_uncorr),
      .inj_en(inj_en), .inj_mask(inj_mask), .clr_cnt(clr_cnt),
      .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one word and hold it until accepted; returns one cycle after acceptance.
   task automatic push_word(input logic [7:0] d);
      int unsigned t = 0;
      in_req  = 1'b1;
      data_in = d;
      while (!in_ack && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      check("push_ack", in_ack, 1);
      @(posedge clk); #1;
      in_req = 1'b0;
   endtask

   // Send one word through an empty pipe and check the delivered head.
   task automatic xfer(input string tag, input logic [7:0] d, input logic md, input logic ie,
                       input logic [15:0] mask, input logic [7:0] exp_d, input logic exp_c,
                       input logic exp_u, input logic [1:0] exp_cc, input logic [1:0] exp_cu,
                       input bit clr_at_push, input int cw_exp);
      int unsigned cyc;
      mode     = md;
      inj_en   = ie;
      inj_mask = mask;
      push_word(d);
      cyc = 1;
      while (!out_req && cyc < 40) begin
         if (cyc == 3 && cw_exp >= 0) check({tag, "_cw"}, dut.cw_q[7:0], cw_exp[7:0]);
         if (cyc == 5 && clr_at_push) clr_cnt = 1'b1;
         @(posedge clk); #1;
         clr_cnt = 1'b0;
         cyc++;
      end
      check({tag, "_lat"},   cyc, 6);
      check({tag, "_data"},  data_out, exp_d);
      check({tag, "_corr"},  err_corr, exp_c);
      check({tag, "_unc"},   err_uncorr, exp_u);
      check({tag, "_cntc"},  cnt_corr, exp_cc);
      check({tag, "_cntu"},  cnt_uncorr, exp_cu);
      out_ack = 1'b1;
      @(posedge clk); #1;
      out_ack = 1'b0;
      check({tag, "_popped"}, out_req, 0);
   endtask

   initial begin
      int unsigned nxt, rx, seen;
      logic        acc;
      rst = 1'b1; en = 1'b1; mode = 1'b1; in_req = 1'b0; out_ack = 1'b0;
      inj_en = 1'b0; clr_cnt = 1'b0; data_in = '0; inj_mask = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ack",  in_ack, 0);
      check("rst_out_req", out_req, 0);
      check("rst_flags",   {err_uncorr, err_corr}, 0);
      check("rst_busy",    busy, 0);
      check("rst_cnts",    {cnt_uncorr, cnt_corr}, 0);
      check("rst_dout",    data_out, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_in_ack", in_ack, 1);
      en = 1'b0; #1;
      check("dis_in_ack", in_ack, 0);
      en = 1'b1;
      @(posedge clk); #1;

      xfer("clean",  8'hA5, 1, 0, 16'h0000, 8'hA5, 0, 0, 2'd0, 2'd0, 0, 8'h5A);
      xfer("single", 8'h3C, 1, 1, 16'h0010, 8'h3C, 1, 0, 2'd1, 2'd0, 0, -1);
      xfer("double", 8'h3C, 1, 1, 16'h0300, 8'h3C, 0, 1, 2'd1, 2'd1, 0, -1);
      xfer("bypass", 8'h96, 0, 1, 16'hFFFF, 8'h96, 0, 0, 2'd1, 2'd1, 0, -1);

      for (int i = 0; i < 5; i++)
         xfer($sformatf("sat%0d", i), 8'h3C, 1, 1, 16'h0010, 8'h3C, 1, 0,
              (i >= 1) ? 2'd3 : 2'd2, 2'd1, 0, -1);
      xfer("clr",    8'h5A, 1, 1, 16'h0010, 8'h5A, 1, 0, 2'd0, 2'd0, 1, -1);
      xfer("two",    8'h3C, 1, 1, 16'h1001, 8'h3C, 1, 0, 2'd2, 2'd0, 0, -1);

      // Reset while the word sits in DEC
      mode = 1'b1; inj_en = 1'b0;
      push_word(8'h77);
      repeat (3) begin @(posedge clk); #1; end
      check("dec_busy", busy, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_out_req", out_req, 0);
      check("abort_busy",    busy, 0);
      check("abort_cnt",     cnt_corr, 0);
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (out_req || busy) seen++;
      end
      check("abort_no_word", seen, 0);

      // Backpressure: offer 0x01..0x0A with the consumer stalled
      out_ack = 1'b0;
      nxt = 1;
      for (int c = 0; c < 80; c++) begin
         in_req  = (nxt <= 10);
         data_in = 8'(nxt);
         acc     = in_req & in_ack;
         @(posedge clk); #1;
         if (acc) nxt++;
      end
      check("bp_accepted",  nxt - 1, 8);
      check("bp_in_ack_lo", in_ack, 0);
      out_ack = 1'b1;
      rx = 0;
      for (int c = 0; c < 200 && rx < 10; c++) begin
         in_req  = (nxt <= 10);
         data_in = 8'(nxt);
         acc     = in_req & in_ack;
         if (out_req) begin
            check($sformatf("bp_rx%0d", rx), data_out, rx + 1);
            rx++;
         end
         @(posedge clk); #1;
         if (acc) nxt++;
      end
      in_req  = 1'b0;
      out_ack = 1'b0;
      check("bp_rx_count",  rx, 10);
      check("bp_all_acc",   nxt - 1, 10);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
